updn_counter_ext: RTL and testbench
===================================

# updn_counter_ext

Parametrised up/down counter: successor to the fixed 16-bit load/count block, used wherever software-programmed event, address or timeout counting is needed. Adds configurable width, programmable step, programmable lower/upper limits, three boundary modes (wrap, saturate, one-shot), a synchronous clear, terminal-count signalling and limit-configuration checking. Keeps the existing control semantics: active-low load, `updn_cnt` = 1 counts up, `count_enb` gates counting.

## Interface
- `WIDTH`, 16, counter and limit width (≥ 2).
- `STEP_W`, 4, width of the step input.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous clear, active-high.
- `ld_cnt`  in  1  load strobe, active-low.
- `data_in`  in  WIDTH  load value.
- `count_enb`  in  1  count enable, active-high.
- `updn_cnt`  in  1  direction: 1 = up, 0 = down.
- `step`  in  STEP_W  increment per enabled cycle (unsigned).
- `lo_lim`  in  WIDTH  lower bound (unsigned).
- `hi_lim`  in  WIDTH  upper bound (unsigned).
- `mode`  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (behaves as SAT).
- `data_out`  out  WIDTH  counter value (registered).
- `tc`  out  1  terminal-count pulse (registered).
- `done`  out  1  one-shot finished (registered).
- `at_hi`  out  1  `data_out == hi_lim` (combinational).
- `at_lo`  out  1  `data_out == lo_lim` (combinational).
- `cfg_err`  out  1  `lo_lim > hi_lim` (combinational).

## Operation
- Priority per edge: `rst_` > `clr` > load (`!ld_cnt`) > count (`count_enb`).
- Reset: `data_out`=0, `tc`=0, `done`=0, FSM=RUN.
- `clr`: `data_out` = `lo_lim`, `tc`=0, FSM=RUN.
- Load: `data_out` = `data_in` unchanged, even if outside [lo_lim, hi_lim]; `tc`=0; FSM=RUN.
- Count: allowed only when FSM=RUN, `cfg_err`=0 and `step`≠0; otherwise `data_out` holds and `tc`=0.
- Arithmetic in WIDTH+2-bit signed: up `nxt = data_out + step`; down `nxt = data_out - step`.
- Boundary hit: up with `nxt > hi_lim`, or down with `nxt < lo_lim`. Landing exactly on a limit is not a hit.
- On a hit: WRAP loads the opposite limit (no remainder carry); SAT loads the crossed limit; ONESHOT loads the crossed limit and moves FSM to DONE. All modes assert `tc` for one cycle on a hit.
- SAT already at the limit and counting further into it: `data_out` holds and `tc` pulses on every enabled cycle.
- FSM, two states. RUN: counting permitted. DONE: `done`=1, counting ignored. DONE → RUN on `clr` or load. A mode change away from ONESHOT also returns DONE → RUN on the next edge.
- Out-of-range start, e.g. after loading above `hi_lim`: the next count evaluates the boundary rule normally. Counting up therefore hits at once; counting down counts normally.
- `tc` must not assert on load, clr, reset, or a disabled cycle.

## Timing
- Every state change is one edge after the qualifying input sample; load and count latency is 1 cycle.
- `tc` is high in the same cycle `data_out` first shows the post-hit value, for exactly one cycle per hit.
- `done` rises with the edge that enters DONE and falls with the edge that leaves it.
- `at_hi`, `at_lo` and `cfg_err` follow limit-input changes in the same cycle; a limit change takes effect on the next count.
- `rst_` asserted mid-count clears immediately, independent of `clk`. Deassertion is synchronised externally.

## Structure
- Package `updn_pkg`: `mode_e` enum (`MODE_WRAP`, `MODE_SAT`, `MODE_ONESHOT`) and `state_e` (`ST_RUN`, `ST_DONE`).
- Sub-module `updn_step_calc`: purely combinational. Inputs are `data_out`, `step`, direction and the limits. Outputs are the next value and a hit flag, with the per-mode limit selection done in the top level.
- The top level holds the registers, priority logic and FSM.

## Test plan
- Reset mid-count at `data_out`=0x1234 → `data_out`=0, `tc`=0, `done`=0 immediately.
- WRAP, lo=10, hi=20, step=3, up from 18 → next value 10 with `tc` pulse. Down from 12 → 20 with `tc`.
- SAT, lo=0, hi=0xFFFF, step=15, up from 0xFFF5 → 0xFFFF with `tc`. Further enabled cycles hold 0xFFFF with `tc` each cycle. Landing exactly on 0xFFFF from 0xFFF0 produces no `tc`.
- ONESHOT, lo=0, hi=5, step=2, up from 0 → 2, 4, then 5 with `tc` and `done`=1. Held at 5 while enabled. Load 1 → `done`=0, counting resumes.
- Simultaneous `clr`, `!ld_cnt` and `count_enb` with lo=7 → `data_out`=7. `!ld_cnt` with `count_enb` and `data_in`=0x40 → 0x40, no count.
- lo=9, hi=3 → `cfg_err`=1 and counting is inhibited, while load of 0x55 still works. `step`=0 → value holds, no `tc`.

Source files
------------

// File: rtl/updn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : updn_pkg                                               |
// | Description : Shared types for the extended up/down counter:         |
// |               boundary-mode and FSM state enums plus a mode decoder. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package updn_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_SAT     = 2'd1,
      MODE_ONESHOT = 2'd2
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   // The reserved encoding 3 folds onto saturate so the rest of the
   // design only ever sees the three legal modes.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      mode_e m;
      case (raw)
         2'd0:    m = MODE_WRAP;
         2'd2:    m = MODE_ONESHOT;
         default: m = MODE_SAT;
      endcase
      return m;
   endfunction

endpackage : updn_pkg
`default_nettype wire

// File: rtl/updn_step_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : updn_step_calc                                         |
// | Description : Combinational next-value and boundary-hit evaluation   |
// |               for one counting step, in WIDTH+2-bit signed space.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module updn_step_calc
   import updn_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STEP_W = 4
) (
   input  logic [WIDTH-1:0]  cnt,
   input  logic [STEP_W-1:0] step,
   input  logic              up,
   input  logic [WIDTH-1:0]  lo_lim,
   input  logic [WIDTH-1:0]  hi_lim,
   output logic [WIDTH-1:0]  nxt_val,
   output logic              hit
);

   // Two guard bits: one absorbs the carry of an up step, the other is
   // the sign of a down step that falls below zero. STEP_W must not
   // exceed WIDTH so the sum cannot overflow the extended range.
   localparam int c_EXT_W = WIDTH + 2;

   logic signed [c_EXT_W-1:0] w_cnt_ext;
   logic signed [c_EXT_W-1:0] w_step_ext;
   logic signed [c_EXT_W-1:0] w_lo_ext;
   logic signed [c_EXT_W-1:0] w_hi_ext;
   logic signed [c_EXT_W-1:0] w_nxt;

   assign w_cnt_ext  = $signed({2'b00, cnt});
   assign w_step_ext = $signed({{(c_EXT_W-STEP_W){1'b0}}, step});
   assign w_lo_ext   = $signed({2'b00, lo_lim});
   assign w_hi_ext   = $signed({2'b00, hi_lim});

   // Raw step result and strict-crossing test; landing on a limit is not a hit.
   always_comb begin
      if (up) begin
         w_nxt = w_cnt_ext + w_step_ext;
         hit   = (w_nxt > w_hi_ext);
      end else begin
         w_nxt = w_cnt_ext - w_step_ext;
         hit   = (w_nxt < w_lo_ext);
      end
      nxt_val = w_nxt[WIDTH-1:0];
   end

endmodule : updn_step_calc
`default_nettype wire

// File: rtl/updn_counter_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : updn_counter_ext                                       |
// | Description : Parametrised up/down counter with programmable step,   |
// |               limits, wrap/saturate/one-shot boundary handling,      |
// |               terminal-count pulse and limit-configuration check.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module updn_counter_ext
   import updn_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              clr,
   input  logic              ld_cnt,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              count_enb,
   input  logic              updn_cnt,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  lo_lim,
   input  logic [WIDTH-1:0]  hi_lim,
   input  logic [1:0]        mode,
   output logic [WIDTH-1:0]  data_out,
   output logic              tc,
   output logic              done,
   output logic              at_hi,
   output logic              at_lo,
   output logic              cfg_err
);

   state_e            state_q;
   state_e            state_d;
   logic [WIDTH-1:0]  data_q;
   logic [WIDTH-1:0]  data_d;
   logic              tc_q;
   logic              tc_d;

   mode_e             w_mode;
   logic              w_cfg_err;
   logic              w_cnt_ok;
   logic              w_hit;
   logic [WIDTH-1:0]  w_nxt_val;
   logic [WIDTH-1:0]  w_crossed_lim;
   logic [WIDTH-1:0]  w_opposite_lim;

   assign w_mode    = decode_mode(mode);
   assign w_cfg_err = (lo_lim > hi_lim);
   assign w_cnt_ok  = count_enb && (state_q == ST_RUN) && !w_cfg_err
                      && (step != '0);

   // Limit that was crossed, and the one a wrap jumps to.
   assign w_crossed_lim  = updn_cnt ? hi_lim : lo_lim;
   assign w_opposite_lim = updn_cnt ? lo_lim : hi_lim;

   updn_step_calc #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_step_calc (
      .cnt     (data_q),
      .step    (step),
      .up      (updn_cnt),
      .lo_lim  (lo_lim),
      .hi_lim  (hi_lim),
      .nxt_val (w_nxt_val),
      .hit     (w_hit)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: clr/load restart, one-shot hit parks, leaving one-shot mode releases.
   always_comb begin
      state_d = state_q;
      if (clr || !ld_cnt) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (w_cnt_ok && w_hit && (w_mode == MODE_ONESHOT)) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (w_mode != MODE_ONESHOT) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      done = (state_q == ST_DONE);
   end

   // Counter value and terminal-count registers.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         data_q <= '0;
         tc_q   <= 1'b0;
      end else begin
         data_q <= data_d;
         tc_q   <= tc_d;
      end
   end

   // Datapath next value in priority order clr > load > count.
   always_comb begin
      data_d = data_q;
      tc_d   = 1'b0;
      if (clr) begin
         data_d = lo_lim;
      end else if (!ld_cnt) begin
         data_d = data_in;
      end else if (w_cnt_ok) begin
         if (w_hit) begin
            tc_d = 1'b1;
            if (w_mode == MODE_WRAP) begin
               data_d = w_opposite_lim;
            end else begin
               data_d = w_crossed_lim;
            end
         end else begin
            data_d = w_nxt_val;
         end
      end
   end

   assign data_out = data_q;
   assign tc       = tc_q;
   assign at_hi    = (data_q == hi_lim);
   assign at_lo    = (data_q == lo_lim);
   assign cfg_err  = w_cfg_err;

endmodule : updn_counter_ext
`default_nettype wire

// File: tb/tb_updn_counter_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_updn_counter_ext                                    |
// | Description : Self-checking bench for updn_counter_ext: directed     |
// |               scenarios then random traffic against an integer       |
// |               reference model.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_updn_counter_ext;

   localparam int WIDTH  = 16;
   localparam int STEP_W = 4;

   logic              clk = 1'b0;
   logic              rst_;
   logic              clr;
   logic              ld_cnt;
   logic [WIDTH-1:0]  data_in;
   logic              count_enb;
   logic              updn_cnt;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  lo_lim;
   logic [WIDTH-1:0]  hi_lim;
   logic [1:0]        mode;
   logic [WIDTH-1:0]  data_out;
   logic              tc;
   logic              done;
   logic              at_hi;
   logic              at_lo;
   logic              cfg_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_val  = 0;
   bit m_tc   = 1'b0;
   bit m_done = 1'b0;

   always #5 clk = ~clk;

   updn_counter_ext #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) dut (
      .clk       (clk),
      .rst_      (rst_),
      .clr       (clr),
      .ld_cnt    (ld_cnt),
      .data_in   (data_in),
      .count_enb (count_enb),
      .updn_cnt  (updn_cnt),
      .step      (step),
      .lo_lim    (lo_lim),
      .hi_lim    (hi_lim),
      .mode      (mode),
      .data_out  (data_out),
      .tc        (tc),
      .done      (done),
      .at_hi     (at_hi),
      .at_lo     (at_lo),
      .cfg_err   (cfg_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
      end
   endtask

   // One rising edge of the counter, expressed with plain integer arithmetic.
   task automatic model_edge();
      int n;
      int lo;
      int hi;
      lo = int'(lo_lim);
      hi = int'(hi_lim);
      m_tc = 1'b0;
      if (!rst_) begin
         m_val  = 0;
         m_done = 1'b0;
      end else if (clr) begin
         m_val  = lo;
         m_done = 1'b0;
      end else if (!ld_cnt) begin
         m_val  = int'(data_in);
         m_done = 1'b0;
      end else if (m_done) begin
         if (mode != 2'd2) m_done = 1'b0;
      end else if (count_enb && lo <= hi && step != 0) begin
         n = updn_cnt ? m_val + int'(step) : m_val - int'(step);
         if ((updn_cnt && n > hi) || (!updn_cnt && n < lo)) begin
            m_tc = 1'b1;
            if (mode == 2'd0) begin
               m_val = updn_cnt ? lo : hi;
            end else begin
               m_val = updn_cnt ? hi : lo;
               if (mode == 2'd2) m_done = 1'b1;
            end
         end else begin
            m_val = n;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data_out"}, 32'(data_out), 32'(m_val));
      chk({tag, ".tc"},       32'(tc),       32'(m_tc));
      chk({tag, ".done"},     32'(done),     32'(m_done));
      chk({tag, ".at_hi"},    32'(at_hi),    32'(m_val == int'(hi_lim)));
      chk({tag, ".at_lo"},    32'(at_lo),    32'(m_val == int'(lo_lim)));
      chk({tag, ".cfg_err"},  32'(cfg_err),  32'(lo_lim > hi_lim));
   endtask

   // Inputs are changed at the falling edge; outputs checked 1 time unit after the rising edge.
   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic set_cfg(input int lo, input int hi, input int st, input int md);
      lo_lim = WIDTH'(lo);
      hi_lim = WIDTH'(hi);
      step   = STEP_W'(st);
      mode   = 2'(md);
   endtask

   task automatic do_load(input int v);
      ld_cnt  = 1'b0;
      data_in = WIDTH'(v);
      cyc("load");
      ld_cnt  = 1'b1;
   endtask

   initial begin
      rst_ = 1'b0; clr = 1'b0; ld_cnt = 1'b1; data_in = '0;
      count_enb = 1'b0; updn_cnt = 1'b1;
      set_cfg(0, 16'hFFFF, 1, 0);
      #2;
      check_all("reset");
      @(negedge clk);
      rst_ = 1'b1;

      // Asynchronous reset in the middle of a counting cycle
      do_load(16'h1234);
      chk("pre_rst", 32'(data_out), 32'h1234);
      count_enb = 1'b1;
      #2 rst_ = 1'b0;
      #1;
      m_val = 0; m_tc = 1'b0; m_done = 1'b0;
      check_all("rst_mid");
      chk("rst_mid_val", 32'(data_out), 32'h0);
      @(negedge clk);
      rst_ = 1'b1;
      count_enb = 1'b0;

      // WRAP up and down
      set_cfg(10, 20, 3, 0);
      do_load(18);
      count_enb = 1'b1; updn_cnt = 1'b1;
      cyc("wrap_up");
      chk("wrap_up_val", 32'(data_out), 32'd10);
      chk("wrap_up_tc", 32'(tc), 32'd1);
      count_enb = 1'b0;
      do_load(12);
      count_enb = 1'b1; updn_cnt = 1'b0;
      cyc("wrap_dn");
      chk("wrap_dn_val", 32'(data_out), 32'd20);
      count_enb = 1'b0;

      // SAT at top of the range
      set_cfg(0, 16'hFFFF, 15, 1);
      do_load(16'hFFF5);
      count_enb = 1'b1; updn_cnt = 1'b1;
      cyc("sat_hit");
      chk("sat_hit_val", 32'(data_out), 32'hFFFF);
      cyc("sat_hold1");
      chk("sat_hold_tc", 32'(tc), 32'd1);
      cyc("sat_hold2");
      count_enb = 1'b0;
      do_load(16'hFFF0);
      count_enb = 1'b1;
      cyc("sat_exact");
      chk("sat_exact_tc", 32'(tc), 32'd0);
      count_enb = 1'b0;

      // ONESHOT
      set_cfg(0, 5, 2, 2);
      do_load(0);
      count_enb = 1'b1; updn_cnt = 1'b1;
      cyc("os_2");
      cyc("os_4");
      cyc("os_hit");
      chk("os_done", 32'(done), 32'd1);
      chk("os_val", 32'(data_out), 32'd5);
      cyc("os_park");
      count_enb = 1'b0;
      do_load(1);
      chk("os_reld_done", 32'(done), 32'd0);
      count_enb = 1'b1;
      cyc("os_resume");
      chk("os_resume_val", 32'(data_out), 32'd3);
      cyc("os_5");
      cyc("os_hit2");
      count_enb = 1'b0;
      mode = 2'd1;
      cyc("os_modechg");
      chk("os_modechg_done", 32'(done), 32'd0);

      // Priority clr > load > count
      set_cfg(7, 100, 1, 0);
      clr = 1'b1; ld_cnt = 1'b0; count_enb = 1'b1; data_in = 16'h33;
      cyc("prio_clr");
      chk("prio_clr_val", 32'(data_out), 32'd7);
      clr = 1'b0; data_in = 16'h40;
      cyc("prio_ld");
      chk("prio_ld_val", 32'(data_out), 32'h40);
      ld_cnt = 1'b1; count_enb = 1'b0;

      // Bad limits inhibit counting but not load; zero step holds
      set_cfg(9, 3, 1, 0);
      count_enb = 1'b1;
      cyc("cfg_err_hold");
      chk("cfg_err_flag", 32'(cfg_err), 32'd1);
      do_load(16'h55);
      chk("cfg_err_load", 32'(data_out), 32'h55);
      set_cfg(0, 16'hFFFF, 0, 0);
      cyc("step0");
      chk("step0_tc", 32'(tc), 32'd0);
      count_enb = 1'b0;

      // Out-of-range start above hi_lim
      set_cfg(10, 20, 1, 1);
      do_load(30);
      count_enb = 1'b1; updn_cnt = 1'b0;
      cyc("oor_dn");
      updn_cnt = 1'b1;
      cyc("oor_up");
      count_enb = 1'b0;

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               lo_lim = WIDTH'($urandom_range(16'hFF00, 16'hFFFF));
               hi_lim = 16'hFFFF;
            end else begin
               lo_lim = WIDTH'($urandom_range(0, 40));
               hi_lim = WIDTH'($urandom_range(0, 80));
            end
         end
         clr       = ($urandom_range(0, 31) == 0);
         ld_cnt    = !($urandom_range(0, 9) == 0);
         data_in   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom)
                                                 : WIDTH'($urandom_range(0, 90));
         count_enb = ($urandom_range(0, 3) != 0);
         updn_cnt  = 1'($urandom);
         step      = STEP_W'($urandom);
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
         cyc("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_updn_counter_ext
`default_nettype wire
